// File: rtl/huff_code_builder.sv
// Iterative Huffman code table builder: loads NUM_SYM (char, freq) pairs, merges the two
// lowest (freq, group id) nodes once per cycle, then streams one code entry per symbol.
module huff_code_builder #(
    parameter int unsigned NUM_SYM = 4,
    parameter int unsigned FREQ_W  = 3,
    parameter int unsigned LEN_W   = $clog2(NUM_SYM),
    parameter int unsigned SUM_W   = FREQ_W + $clog2(NUM_SYM)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_char,
    input  logic [FREQ_W-1:0]    in_freq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_char,
    output logic [LEN_W-1:0]     out_len,
    output logic [NUM_SYM-2:0]   out_code,
    output logic                 done
);

    localparam int unsigned IDX_W  = $clog2(NUM_SYM);
    localparam int unsigned CODE_W = NUM_SYM - 1;

    typedef enum logic [1:0] {ST_LOAD, ST_MERGE, ST_EMIT, ST_DONE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     ld_cnt, ld_cnt_nxt;
    logic [IDX_W-1:0]     mrg_cnt, mrg_cnt_nxt;
    logic [IDX_W-1:0]     em_cnt, em_cnt_nxt;
    logic [IDX_W-1:0]     em_idx;
    logic [7:0]           chr       [NUM_SYM];
    logic [7:0]           chr_nxt   [NUM_SYM];
    logic [SUM_W-1:0]     nfreq     [NUM_SYM];
    logic [SUM_W-1:0]     nfreq_nxt [NUM_SYM];
    logic [IDX_W-1:0]     grp       [NUM_SYM];
    logic [IDX_W-1:0]     grp_nxt   [NUM_SYM];
    logic [LEN_W-1:0]     len       [NUM_SYM];
    logic [LEN_W-1:0]     len_nxt   [NUM_SYM];
    logic [CODE_W-1:0]    code      [NUM_SYM];
    logic [CODE_W-1:0]    code_nxt  [NUM_SYM];
    logic [NUM_SYM-1:0]   active, active_nxt;

    logic                 in_ready_nxt, out_valid_nxt, done_nxt;
    logic [7:0]           out_char_nxt;
    logic [LEN_W-1:0]     out_len_nxt;
    logic [CODE_W-1:0]    out_code_nxt;

    logic                 a_ok, b_ok;
    logic [IDX_W-1:0]     a_id, b_id, m_id, o_id;
    logic [SUM_W-1:0]     a_f, b_f;

    // Two smallest active nodes; ascending scan with strict compare breaks ties to lower id
    always_comb begin
        a_ok = 1'b0;
        a_id = '0;
        a_f  = '0;
        b_ok = 1'b0;
        b_id = '0;
        b_f  = '0;
        for (int k = 0; k < NUM_SYM; k++) begin
            if (active[k] && (!a_ok || nfreq[k] < a_f)) begin
                a_ok = 1'b1;
                a_id = IDX_W'(k);
                a_f  = nfreq[k];
            end
        end
        for (int k = 0; k < NUM_SYM; k++) begin
            if (active[k] && IDX_W'(k) != a_id && (!b_ok || nfreq[k] < b_f)) begin
                b_ok = 1'b1;
                b_id = IDX_W'(k);
                b_f  = nfreq[k];
            end
        end
        m_id = (a_id < b_id) ? a_id : b_id;
        o_id = (a_id < b_id) ? b_id : a_id;
    end

    always_comb begin
        state_nxt     = state;
        ld_cnt_nxt    = ld_cnt;
        mrg_cnt_nxt   = mrg_cnt;
        em_cnt_nxt    = em_cnt;
        em_idx        = em_cnt + 1'b1;
        chr_nxt       = chr;
        nfreq_nxt     = nfreq;
        grp_nxt       = grp;
        len_nxt       = len;
        code_nxt      = code;
        active_nxt    = active;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        out_char_nxt  = out_char;
        out_len_nxt   = out_len;
        out_code_nxt  = out_code;
        done_nxt      = 1'b0;

        case (state)
            ST_LOAD: begin
                if (in_valid && in_ready) begin
                    chr_nxt[ld_cnt]    = in_char;
                    nfreq_nxt[ld_cnt]  = SUM_W'(in_freq);
                    grp_nxt[ld_cnt]    = ld_cnt;
                    len_nxt[ld_cnt]    = '0;
                    code_nxt[ld_cnt]   = '0;
                    active_nxt[ld_cnt] = 1'b1;
                    if (ld_cnt == IDX_W'(NUM_SYM - 1)) begin
                        ld_cnt_nxt   = '0;
                        in_ready_nxt = 1'b0;
                        state_nxt    = ST_MERGE;
                    end else begin
                        ld_cnt_nxt = ld_cnt + 1'b1;
                    end
                end
            end
            ST_MERGE: begin
                // Group A prepends a 0, group B a 1; codes grow from the leaf side
                for (int s = 0; s < NUM_SYM; s++) begin
                    if (grp[s] == a_id) begin
                        len_nxt[s] = len[s] + 1'b1;
                    end else if (grp[s] == b_id) begin
                        code_nxt[s] = code[s] | (CODE_W'(1) << len[s]);
                        len_nxt[s]  = len[s] + 1'b1;
                    end
                    if (grp[s] == o_id) begin
                        grp_nxt[s] = m_id;
                    end
                end
                nfreq_nxt[m_id]  = a_f + b_f;
                active_nxt[o_id] = 1'b0;
                if (mrg_cnt == IDX_W'(NUM_SYM - 2)) begin
                    mrg_cnt_nxt   = '0;
                    em_cnt_nxt    = '0;
                    state_nxt     = ST_EMIT;
                    out_valid_nxt = 1'b1;
                    out_char_nxt  = chr[0];
                    out_len_nxt   = len_nxt[0];
                    out_code_nxt  = code_nxt[0];
                end else begin
                    mrg_cnt_nxt = mrg_cnt + 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (em_cnt == IDX_W'(NUM_SYM - 1)) begin
                        em_cnt_nxt    = '0;
                        out_valid_nxt = 1'b0;
                        state_nxt     = ST_DONE;
                    end else begin
                        em_cnt_nxt   = em_idx;
                        out_char_nxt = chr[em_idx];
                        out_len_nxt  = len[em_idx];
                        out_code_nxt = code[em_idx];
                    end
                end
            end
            ST_DONE: begin
                done_nxt     = 1'b1;
                in_ready_nxt = 1'b1;
                state_nxt    = ST_LOAD;
            end
            default: begin
                in_ready_nxt  = 1'b1;
                out_valid_nxt = 1'b0;
                state_nxt     = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            ld_cnt    <= '0;
            mrg_cnt   <= '0;
            em_cnt    <= '0;
            active    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_char  <= '0;
            out_len   <= '0;
            out_code  <= '0;
            done      <= 1'b0;
            for (int s = 0; s < NUM_SYM; s++) begin
                chr[s]   <= '0;
                nfreq[s] <= '0;
                grp[s]   <= '0;
                len[s]   <= '0;
                code[s]  <= '0;
            end
        end else begin
            state     <= state_nxt;
            ld_cnt    <= ld_cnt_nxt;
            mrg_cnt   <= mrg_cnt_nxt;
            em_cnt    <= em_cnt_nxt;
            active    <= active_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_char  <= out_char_nxt;
            out_len   <= out_len_nxt;
            out_code  <= out_code_nxt;
            done      <= done_nxt;
            chr       <= chr_nxt;
            nfreq     <= nfreq_nxt;
            grp       <= grp_nxt;
            len       <= len_nxt;
            code      <= code_nxt;
        end
    end

endmodule
